// File: rtl/uart_rx_frame_parser.sv
// rtl/uart_rx_frame_parser.sv - drains the UART rx FIFO and decodes SOF/LEN/PAYLOAD/CHK frames
// Payload bytes leave on a valid/ready stream; each frame ends in a frame_ok or frame_err pulse.
module uart_rx_frame_parser #(
  parameter int         data_size = 8,
  parameter int         MAX_LEN   = 255,
  parameter logic [7:0] SOF       = 8'h7E,
  parameter int         TIMEOUT   = 100000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_empty,
  input  logic [data_size-1:0] r_data,
  output logic                 rd_uart,
  output logic [7:0]           m_data,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 frame_ok,
  output logic                 frame_err,
  output logic [1:0]           err_code,
  output logic [7:0]           frame_len
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CHK} state_t;

  state_t         state;
  logic           pend;
  logic [7:0]     acc;
  logic [7:0]     count;
  logic [7:0]     len_q;
  logic [TW-1:0]  timer;

  logic           stalled;
  logic           handshake;
  logic           timer_run;
  logic [7:0]     byte_in;
  logic [7:0]     sum;

  assign byte_in   = r_data[7:0];
  assign sum       = acc + byte_in;
  assign handshake = m_valid && m_ready;
  assign stalled   = m_valid && !m_ready;
  // Gated by reset_n so no FIFO byte is popped and lost while the parser is held in reset.
  assign rd_uart   = reset_n && !rx_empty && !pend && (state != PAYLOAD || !stalled);
  assign timer_run = (state != IDLE) && !pend && !stalled;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      pend      <= 1'b0;
      acc       <= 8'd0;
      count     <= 8'd0;
      len_q     <= 8'd0;
      timer     <= '0;
      m_data    <= 8'd0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      frame_len <= 8'd0;
    end else begin
      pend      <= rd_uart;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      if (handshake) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end

      if (state == IDLE || pend)
        timer <= '0;
      else if (timer_run)
        timer <= timer + 1'b1;

      // A capture wins over a timeout landing in the same cycle.
      if (pend) begin
        case (state)
          IDLE: begin
            if (byte_in == SOF) begin
              acc   <= 8'd0;
              state <= LEN;
            end
          end
          LEN: begin
            if (byte_in == 8'd0 || int'(byte_in) > MAX_LEN) begin
              frame_err <= 1'b1;
              err_code  <= 2'd1;
              state     <= IDLE;
            end else begin
              len_q <= byte_in;
              count <= byte_in;
              acc   <= byte_in;
              state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            m_data  <= byte_in;
            m_valid <= 1'b1;
            m_last  <= (count == 8'd1);
            acc     <= sum;
            count   <= count - 8'd1;
            if (count == 8'd1)
              state <= CHK;
          end
          CHK: begin
            if (sum == 8'd0) begin
              frame_ok <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'd2;
            end
            frame_len <= len_q;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (timer_run && timer == TW'(TIMEOUT - 1)) begin
        frame_err <= 1'b1;
        err_code  <= 2'd3;
        state     <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// tb/tb_uart_rx_frame_parser.sv - scoreboard bench for uart_rx_frame_parser
// Stimulus pushes FIFO bytes and expected beats/status; a negedge monitor pops and compares.
module tb_uart_rx_frame_parser;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'd0;
  logic       rd_uart;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready = 1'b1;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] frame_len;

  typedef struct {logic [7:0] d; logic l;} beat_t;
  typedef struct {logic ok; logic [1:0] code; logic [7:0] len;} stat_t;

  logic [7:0] fifo[$];
  beat_t      exp_beats[$];
  stat_t      exp_stats[$];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int last_rd = -10;
  int err_cyc = -1;
  logic stall_chk = 1'b0;

  uart_rx_frame_parser #(.data_size(8), .MAX_LEN(255), .SOF(8'h7E), .TIMEOUT(50)) dut (
    .clk(clk), .reset_n(reset_n), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .frame_len(frame_len)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears on r_data the cycle after rd_uart.
  always @(posedge clk) begin
    if (rd_uart && fifo.size() > 0) r_data <= fifo.pop_front();
    rx_empty <= (fifo.size() == 0);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (rd_uart) begin
        check("rd_spacing_ok", 32'(cyc - last_rd >= 2), 32'd1);
        last_rd = cyc;
      end
      if (stall_chk && m_valid && !m_ready) begin
        check("stall_data", 32'(m_data), 32'h11);
        check("stall_no_rd", 32'(rd_uart), 32'd0);
      end
      if (m_valid && m_ready) begin
        if (exp_beats.size() == 0) begin
          check("unexpected_beat", 32'(m_data), 32'hFFFF);
        end else begin
          beat_t b;
          b = exp_beats.pop_front();
          check("m_data", 32'(m_data), 32'(b.d));
          check("m_last", 32'(m_last), 32'(b.l));
        end
      end
      if (frame_ok || frame_err) begin
        if (frame_err && err_code == 2'd3) err_cyc = cyc;
        if (exp_stats.size() == 0) begin
          check("unexpected_status", {frame_ok, frame_err}, 32'd0);
        end else begin
          stat_t s;
          s = exp_stats.pop_front();
          check("frame_ok", 32'(frame_ok), 32'(s.ok));
          check("frame_err", 32'(frame_err), 32'(!s.ok));
          if (!s.ok) check("err_code", 32'(err_code), 32'(s.code));
          if (s.ok || s.code == 2'd2) check("frame_len", 32'(frame_len), 32'(s.len));
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    @(posedge clk); #1;
    fifo.push_back(b);
    rx_empty = 1'b0;
  endtask

  task automatic exp_beat(input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d; b.l = l;
    exp_beats.push_back(b);
  endtask

  task automatic exp_stat(input logic ok, input logic [1:0] code, input logic [7:0] len);
    stat_t s;
    s.ok = ok; s.code = code; s.len = len;
    exp_stats.push_back(s);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((fifo.size() != 0 || exp_beats.size() != 0 || exp_stats.size() != 0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drained"}, 32'(n < 500), 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_m_valid"}, 32'(m_valid), 32'd0);
    check({name, "_m_data"}, 32'(m_data), 32'd0);
    check({name, "_m_last"}, 32'(m_last), 32'd0);
    check({name, "_status"}, {frame_ok, frame_err}, 32'd0);
    check({name, "_err_code"}, 32'(err_code), 32'd0);
    check({name, "_frame_len"}, 32'(frame_len), 32'd0);
    check({name, "_rd_uart"}, 32'(rd_uart), 32'd0);
  endtask

  initial begin
    logic [7:0] good[6]  = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    logic [7:0] bad[6]   = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h96};
    logic [7:0] resync[8] = '{8'h00, 8'hFF, 8'h7E, 8'h00, 8'h7E, 8'h01, 8'h55, 8'hAA};
    logic [7:0] short_f[4] = '{8'h7E, 8'h01, 8'hAA, 8'h55};
    int n;

    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset_n = 1'b1;

    // Good frame: 03+11+22+33+97 = 0x100.
    exp_beat(8'h11, 0); exp_beat(8'h22, 0); exp_beat(8'h33, 1); exp_stat(1, 2'd0, 8'd3);
    foreach (good[i]) push(good[i]);
    drain("good");

    // Checksum off by one -> code 2.
    exp_beat(8'h11, 0); exp_beat(8'h22, 0); exp_beat(8'h33, 1); exp_stat(0, 2'd2, 8'd3);
    foreach (bad[i]) push(bad[i]);
    drain("bad_chk");

    // Junk dropped, LEN=0 rejected, then 01+55+AA = 0x100.
    exp_stat(0, 2'd1, 8'd0); exp_beat(8'h55, 1); exp_stat(1, 2'd0, 8'd1);
    foreach (resync[i]) push(resync[i]);
    drain("resync");

    // Backpressure on the first payload byte.
    m_ready = 1'b0;
    exp_beat(8'h11, 0); exp_beat(8'h22, 0); exp_beat(8'h33, 1); exp_stat(1, 2'd0, 8'd3);
    foreach (good[i]) push(good[i]);
    n = 0;
    while (!m_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_first_valid", 32'(n < 100), 32'd1);
    stall_chk = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    stall_chk = 1'b0;
    m_ready = 1'b1;
    drain("backpressure");

    // Timeout mid-payload: frame_err 52 cycles after the last read pulse.
    err_cyc = -1;
    exp_beat(8'h11, 0); exp_stat(0, 2'd3, 8'd0);
    push(8'h7E); push(8'h02); push(8'h11);
    repeat (70) @(posedge clk);
    #1;
    check("timeout_latency", 32'(err_cyc - last_rd), 32'd52);
    exp_beat(8'hAA, 1); exp_stat(1, 2'd0, 8'd1);
    foreach (short_f[i]) push(short_f[i]);
    drain("after_timeout");

    // Reset mid-frame discards it silently.
    exp_beat(8'h11, 0);
    push(8'h7E); push(8'h02); push(8'h11);
    repeat (8) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_zero_outputs("mid_reset");
    exp_beat(8'hAA, 1); exp_stat(1, 2'd0, 8'd1);
    foreach (short_f[i]) push(short_f[i]);
    drain("after_reset");

    check("beats_left", 32'(exp_beats.size()), 32'd0);
    check("stats_left", 32'(exp_stats.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
